// File: rtl/scope_capture.sv
// rtl/scope_capture.sv - dual-channel triggered capture buffer with valid/ready readout
// Optional: define SCOPE_TRIG_HYST_EN to require a dip below trig_level-HYST before a trigger.
module scope_capture #(
    parameter int D_WIDTH    = 8,
`ifdef SCOPE_TRIG_HYST_EN
    parameter int HYST       = 4,
`endif
    parameter int DEPTH_LOG2 = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] din1,
    input  logic [D_WIDTH-1:0] din2,
    input  logic [D_WIDTH-1:0] trig_level,
    input  logic               arm,
    input  logic               abort,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [D_WIDTH-1:0] rd_data1,
    output logic [D_WIDTH-1:0] rd_data2,
    output logic               rd_last,
    output logic               armed,
    output logic               busy,
    output logic               done
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_READOUT} state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [D_WIDTH-1:0]    prev1_q, prev1_d;
    logic                  prev_valid_q, prev_valid_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic [D_WIDTH-1:0]    rd_data1_q, rd_data1_d;
    logic [D_WIDTH-1:0]    rd_data2_q, rd_data2_d;
    logic                  wr_en;
    logic                  done_c;
    logic                  trig;
    logic                  qual_ok;
    logic                  xfer;

    logic [D_WIDTH-1:0] mem1 [DEPTH];
    logic [D_WIDTH-1:0] mem2 [DEPTH];

`ifdef SCOPE_TRIG_HYST_EN
    logic               qual_q, qual_d;
    logic [D_WIDTH-1:0] hyst_thr;

    always_comb begin
        hyst_thr = '0;
        if (trig_level > D_WIDTH'(HYST)) hyst_thr = trig_level - D_WIDTH'(HYST);
    end
    assign qual_ok = qual_q;
`else
    assign qual_ok = 1'b1;
`endif

    assign trig = prev_valid_q && (prev1_q < trig_level) && (din1 >= trig_level) && qual_ok;
    assign xfer = rd_valid_q && rd_ready;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        prev1_d      = prev1_q;
        prev_valid_d = prev_valid_q;
        rd_valid_d   = rd_valid_q;
        rd_last_d    = rd_last_q;
        rd_data1_d   = rd_data1_q;
        rd_data2_d   = rd_data2_q;
        wr_en        = 1'b0;
        done_c       = 1'b0;
`ifdef SCOPE_TRIG_HYST_EN
        qual_d       = qual_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d      = S_ARMED;
                    prev_valid_d = 1'b0;
                    wr_ptr_d     = '0;
`ifdef SCOPE_TRIG_HYST_EN
                    qual_d       = 1'b0;
`endif
                end
            end
            S_ARMED: begin
                if (en) begin
                    prev1_d      = din1;
                    prev_valid_d = 1'b1;
`ifdef SCOPE_TRIG_HYST_EN
                    if (din1 < hyst_thr) qual_d = 1'b1;
`endif
                    // wr_ptr_q is 0 here, so the trigger sample lands at index 0
                    if (trig) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = DEPTH_LOG2'(1);
                        state_d  = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (en) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == '1) begin
                        state_d  = S_READOUT;
                        rd_ptr_d = '0;
                    end
                end
            end
            S_READOUT: begin
                // Output register doubles as the prefetch stage: refill on entry and on every non-final transfer
                if (!rd_valid_q || (xfer && !rd_last_q)) begin
                    rd_data1_d = mem1[rd_ptr_q];
                    rd_data2_d = mem2[rd_ptr_q];
                    rd_valid_d = 1'b1;
                    rd_last_d  = (rd_ptr_q == '1);
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                end else if (xfer && rd_last_q) begin
                    done_c     = 1'b1;
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d      = S_IDLE;
            wr_en        = 1'b0;
            done_c       = 1'b0;
            rd_valid_d   = 1'b0;
            rd_last_d    = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            prev_valid_d = 1'b0;
`ifdef SCOPE_TRIG_HYST_EN
            qual_d       = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            prev1_q      <= '0;
            prev_valid_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_data1_q   <= '0;
            rd_data2_q   <= '0;
`ifdef SCOPE_TRIG_HYST_EN
            qual_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            prev1_q      <= prev1_d;
            prev_valid_q <= prev_valid_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            rd_data1_q   <= rd_data1_d;
            rd_data2_q   <= rd_data2_d;
`ifdef SCOPE_TRIG_HYST_EN
            qual_q       <= qual_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem1[wr_ptr_q] <= din1;
            mem2[wr_ptr_q] <= din2;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;
    assign armed    = (state_q == S_ARMED);
    assign busy     = (state_q != S_IDLE);
    assign done     = done_c;
endmodule
